// File: rtl/bullet_pool.sv
// Pool of N_BULLETS projectiles that are fired from the ship column and climb toward row 0.
// Optional refire lockout is enabled by defining BULLET_POOL_COOLDOWN_EN.
module bullet_pool #(
  parameter int N_BULLETS = 4,
  parameter int X_W       = 5,
  parameter int Y_W       = 4,
  parameter int Y_START   = 13,
  parameter int Y_IDLE    = 14,
  parameter int COOLDOWN  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     shoot,
  input  logic [X_W-1:0]           posH,
  input  logic [N_BULLETS-1:0]     hit,
  output logic [N_BULLETS-1:0]     flying,
  output logic [N_BULLETS*X_W-1:0] bulletX,
  output logic [N_BULLETS*Y_W-1:0] bulletY,
  output logic                     fired,
  output logic                     full
);

  logic [N_BULLETS-1:0]     flying_q, flying_d;
  logic [N_BULLETS*X_W-1:0] x_q, x_d;
  logic [N_BULLETS*Y_W-1:0] y_q, y_d;
  logic                     fired_q, fired_d;
  logic [N_BULLETS-1:0]     free_slots;
  logic [N_BULLETS-1:0]     alloc_sel;
  logic                     accept;

  assign full       = &flying_q;
  assign free_slots = ~flying_q;
  // Isolate the lowest set bit: the lowest-index slot that was idle at the start of the tick.
  assign alloc_sel  = free_slots & (~free_slots + N_BULLETS'(1));

`ifdef BULLET_POOL_COOLDOWN_EN
  logic [3:0] cool_q, cool_d;

  assign accept = enable & shoot & ~full & (cool_q == 4'd0);

  always_comb begin
    cool_d = cool_q;
    if (accept) begin
      cool_d = 4'(COOLDOWN);
    end else if (enable && (cool_q != 4'd0)) begin
      cool_d = cool_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cool_q <= 4'd0;
    end else begin
      cool_q <= cool_d;
    end
  end
`else
  assign accept = enable & shoot & ~full;
`endif

  always_comb begin
    flying_d = flying_q;
    x_d      = x_q;
    y_d      = y_q;
    fired_d  = accept;
    if (enable) begin
      for (int i = 0; i < N_BULLETS; i++) begin
        if (flying_q[i]) begin
          if (hit[i]) begin
            flying_d[i]           = 1'b0;
            y_d[i*Y_W +: Y_W]     = Y_W'(Y_IDLE);
          end else if (y_q[i*Y_W +: Y_W] == '0) begin
            flying_d[i]           = 1'b0;
            y_d[i*Y_W +: Y_W]     = Y_W'(Y_IDLE);
          end else begin
            y_d[i*Y_W +: Y_W]     = y_q[i*Y_W +: Y_W] - Y_W'(1);
          end
        end else if (accept && alloc_sel[i]) begin
          // A freshly fired slot sits at Y_START for its firing tick and starts moving on the next.
          flying_d[i]           = 1'b1;
          x_d[i*X_W +: X_W]     = posH;
          y_d[i*Y_W +: Y_W]     = Y_W'(Y_START);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flying_q <= '0;
      x_q      <= '0;
      y_q      <= {N_BULLETS{Y_W'(Y_IDLE)}};
      fired_q  <= 1'b0;
    end else begin
      flying_q <= flying_d;
      x_q      <= x_d;
      y_q      <= y_d;
      fired_q  <= fired_d;
    end
  end

  assign flying  = flying_q;
  assign bulletX = x_q;
  assign bulletY = y_q;
  assign fired   = fired_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: a slot-level game model checked every cycle plus pinned literals.
// Works in both builds; define BULLET_POOL_COOLDOWN_EN to exercise the refire lockout.
module tb_bullet_pool;

  localparam int NB   = 4;
  localparam int XW   = 5;
  localparam int YW   = 4;
  localparam int YST  = 13;
  localparam int YIDL = 14;
  localparam int COOL = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              shoot;
  logic [XW-1:0]     posH;
  logic [NB-1:0]     hit;
  logic [NB-1:0]     flying;
  logic [NB*XW-1:0]  bulletX;
  logic [NB*YW-1:0]  bulletY;
  logic              fired;
  logic              full;

  int vectors    = 0;
  int miscompares = 0;

  bullet_pool dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .shoot   (shoot),
    .posH    (posH),
    .hit     (hit),
    .flying  (flying),
    .bulletX (bulletX),
    .bulletY (bulletY),
    .fired   (fired),
    .full    (full)
  );

  always #5 clk = ~clk;

  // Game-level model: each bullet is a record (active, column, row).
  bit m_fly [NB];
  int m_x   [NB];
  int m_y   [NB];
  bit m_fired;
  int m_cool;
  bit m_valid = 1'b0;
  int first_free;
  bit all_busy;
  bit take;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        m_fly[i] = 1'b0;
        m_x[i]   = 0;
        m_y[i]   = YIDL;
      end
      m_fired = 1'b0;
      m_cool  = 0;
      m_valid = 1'b1;
    end else if (enable) begin
      first_free = -1;
      all_busy   = 1'b1;
      for (int i = 0; i < NB; i++) begin
        if (!m_fly[i]) begin
          all_busy = 1'b0;
          if (first_free < 0) first_free = i;
        end
      end
      take = shoot && !all_busy;
`ifdef BULLET_POOL_COOLDOWN_EN
      take = take && (m_cool == 0);
`endif
      for (int i = 0; i < NB; i++) begin
        if (m_fly[i]) begin
          if (hit[i] || m_y[i] == 0) begin
            m_fly[i] = 1'b0;
            m_y[i]   = YIDL;
          end else begin
            m_y[i] = m_y[i] - 1;
          end
        end
      end
      if (take) begin
        m_fly[first_free] = 1'b1;
        m_x[first_free]   = int'(posH);
        m_y[first_free]   = YST;
      end
      m_fired = take;
      if (take) m_cool = COOL;
      else if (m_cool > 0) m_cool = m_cool - 1;
    end else begin
      m_fired = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every settled cycle, the registered outputs must match the model.
  logic [NB-1:0]    e_fly;
  logic [NB*XW-1:0] e_x;
  logic [NB*YW-1:0] e_y;
  bit               e_full;

  always @(negedge clk) begin
    if (m_valid) begin
      e_full = 1'b1;
      for (int i = 0; i < NB; i++) begin
        e_fly[i]          = m_fly[i];
        e_x[i*XW +: XW]   = XW'(m_x[i]);
        e_y[i*YW +: YW]   = YW'(m_y[i]);
        e_full            = e_full & m_fly[i];
      end
      checkOutput("model_flying",  int'(flying),  int'(e_fly));
      checkOutput("model_bulletX", int'(bulletX), int'(e_x));
      checkOutput("model_bulletY", int'(bulletY), int'(e_y));
      checkOutput("model_fired",   int'(fired),   int'(m_fired));
      checkOutput("model_full",    int'(full),    int'(e_full));
    end
  end

  task automatic applyStimulus(input logic r, input logic e, input logic s,
                               input logic [XW-1:0] p, input logic [NB-1:0] h);
    @(negedge clk);
    reset  = r;
    enable = e;
    shoot  = s;
    posH   = p;
    hit    = h;
    @(posedge clk);
    #1;
  endtask

  function automatic int slot_x(input int i);
    return int'(bulletX[i*XW +: XW]);
  endfunction

  function automatic int slot_y(input int i);
    return int'(bulletY[i*YW +: YW]);
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b0; shoot = 1'b0; posH = '0; hit = '0;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rst_flying",  int'(flying),  0);
    checkOutput("rst_bulletX", int'(bulletX), 0);
    checkOutput("rst_bulletY", int'(bulletY), 16'hEEEE);
    checkOutput("rst_fired",   int'(fired),   0);

    // First shot lands in slot 0 and climbs one row per tick.
    applyStimulus(0, 1, 1, 7, 0);
    checkOutput("shot_flying", int'(flying), 1);
    checkOutput("shot_x0",     slot_x(0),    7);
    checkOutput("shot_y0",     slot_y(0),    13);
    checkOutput("shot_fired",  int'(fired),  1);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("move_y0_12",  slot_y(0),    12);
    checkOutput("move_fired0", int'(fired),  0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("move_y0_11",  slot_y(0),    11);
    repeat (11) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("top_y0_0",    slot_y(0),    0);
    checkOutput("top_fly0",    int'(flying), 1);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("retire_fly",  int'(flying), 0);
    checkOutput("retire_y0",   slot_y(0),    14);
    checkOutput("retire_x0",   slot_x(0),    7);

    // Ticks disabled: nothing moves despite shoot and hit.
    applyStimulus(0, 1, 1, 20, 0);
    checkOutput("refire_x0",   slot_x(0),    20);
    repeat (10) begin
      applyStimulus(0, 0, 1, 5, 4'hF);
      checkOutput("hold_fired", int'(fired), 0);
    end
    checkOutput("hold_y0",     slot_y(0),    13);
    checkOutput("hold_fly",    int'(flying), 1);

    // Hit on slot 1 while slot 0 keeps flying and a new shot takes slot 2.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 2, 0);
    repeat (3) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 4, 0);
    repeat (8) applyStimulus(0, 1, 0, 0, 0);
    checkOutput("pre_hit_y1",  slot_y(1),    5);
    checkOutput("pre_hit_y0",  slot_y(0),    1);
    applyStimulus(0, 1, 1, 3, 4'b0010);
    checkOutput("hit_flying",  int'(flying), 4'b0101);
    checkOutput("hit_y1",      slot_y(1),    14);
    checkOutput("hit_x1",      slot_x(1),    4);
    checkOutput("hit_y0",      slot_y(0),    0);
    checkOutput("hit_y2",      slot_y(2),    13);
    checkOutput("hit_x2",      slot_x(2),    3);
    applyStimulus(0, 1, 0, 0, 4'b1000);
    checkOutput("idle_hit_fly", int'(flying), 4'b0100);
    checkOutput("idle_hit_y2",  slot_y(2),    12);

    // Reset mid-flight discards everything; next tick accepts into slot 0.
    repeat (4) applyStimulus(0, 1, 1, 11, 0);
    applyStimulus(1, 1, 1, 9, 4'hF);
    checkOutput("midrst_fly",  int'(flying),  0);
    checkOutput("midrst_y",    int'(bulletY), 16'hEEEE);
    checkOutput("midrst_fired", int'(fired),  0);
    applyStimulus(0, 1, 1, 9, 0);
    checkOutput("postrst_fly", int'(flying), 1);
    checkOutput("postrst_x0",  slot_x(0),    9);
    checkOutput("postrst_fired", int'(fired), 1);

    // Held trigger fills the pool; later traffic uses mixed hits.
    applyStimulus(1, 0, 0, 0, 0);
    for (int k = 0; k < 13; k++) applyStimulus(0, 1, 1, XW'(k + 1), 0);
    checkOutput("hold_full",   int'(full),   1);
    checkOutput("hold_fly_all", int'(flying), 4'hF);
    for (int k = 0; k < 20; k++)
      applyStimulus(0, 1, 1'($urandom_range(0, 1)), XW'($urandom_range(0, 31)),
                    NB'($urandom_range(0, 15)));

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
